// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver (and the future transmitter).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_bit_clks(input int clk_hz, input int bps);
        return (clk_hz + bps / 2) / bps;
    endfunction

    // Parity bit the transmitter should have sent for this word.
    function automatic logic parity_bit(input logic [8:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Word output handshake of the UART receiver: word plus status flags, valid/ready.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;

    modport master (
        output data, data_valid, parity_err, frame_err, break_det, overrun,
        input  data_ready
    );

    modport slave (
        input  data, data_valid, parity_err, frame_err, break_det, overrun,
        output data_ready
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time down-counter with half-bit and full-bit strobes; shared by RX and TX.
module uart_bit_timer #(
    parameter int BIT_CLKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic half_tick,
    output logic full_tick
);
    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LOAD = CW'(BIT_CLKS - 1);
    // Down-count equivalent of "elapsed == BIT_CLKS/2".
    localparam logic [CW-1:0] HALF = CW'(BIT_CLKS - 1 - BIT_CLKS / 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable) begin
            count <= (count == '0) ? LOAD : count - 1'b1;
        end
    end

    assign half_tick = enable && (count == HALF);
    assign full_tick = enable && (count == '0);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, parity/framing/break detection,
// valid/ready output with overrun pulse.
//
// state | meaning
// IDLE  | waiting for a 1->0 transition on the synchronised line
// START | timing half a bit to confirm the start bit (false-start rejection)
// DATA  | sampling DATA_BITS data bits, LSB first
// PAR   | sampling the parity bit
// STOP  | sampling STOP_BITS stop bits; the last one completes the frame
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 66_000_000,
    parameter int BITRATE_BPS = 9_600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    uart_rx_param_if.master        rx_if
);
    localparam int      BIT_CLKS  = calc_bit_clks(CLK_HZ, BITRATE_BPS);
    localparam int      BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam parity_e PAR_MODE  = parity_e'(PARITY[1:0]);

    logic rx_m, rx_s, rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    rx_state_e             state;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [BW-1:0]         bit_idx;
    logic                  par_flag;
    logic                  frm_flag;
    logic                  par_sample;
    logic                  half_tick, full_tick;
    logic                  tmr_clear, tmr_en;
    logic                  frm_now;
    logic                  brk_now;

    logic [DATA_BITS-1:0]  data_q;
    logic                  valid_q, perr_q, ferr_q, brk_q, ovr_q;

    // The timer sits parked at the start of a bit while idle and restarts
    // at the confirmed start-bit midpoint so later ticks land mid-bit.
    assign tmr_clear = (state == IDLE) || (state == START && half_tick);
    assign tmr_en    = (state != IDLE);

    uart_bit_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .enable    (tmr_en),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    assign frm_now = frm_flag | ~rx_s;
    assign brk_now = frm_now && (shift_reg == '0) &&
                     (PAR_MODE == PAR_NONE || !par_sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_idx    <= '0;
            par_flag   <= 1'b0;
            frm_flag   <= 1'b0;
            par_sample <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (valid_q && rx_if.data_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_tick) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state      <= DATA;
                            bit_idx    <= '0;
                            par_flag   <= 1'b0;
                            frm_flag   <= 1'b0;
                            par_sample <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (full_tick) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PAR_MODE != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (full_tick) begin
                        par_sample <= rx_s;
                        par_flag   <= rx_s != parity_bit(9'(shift_reg), PAR_MODE == PAR_ODD);
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (full_tick) begin
                        if (bit_idx == LAST_STOP) begin
                            state   <= IDLE;
                            bit_idx <= '0;
                            if (!valid_q || rx_if.data_ready) begin
                                data_q  <= shift_reg;
                                valid_q <= 1'b1;
                                perr_q  <= par_flag;
                                ferr_q  <= frm_now;
                                brk_q   <= brk_now;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            frm_flag <= frm_now;
                            bit_idx  <= bit_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.data       = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.parity_err = perr_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.break_det  = brk_q;
    assign rx_if.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: 8N1, 8E1 and 7N2 instances at 10 clocks per bit.
module tb_uart_rx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if_a ();
    uart_rx_param_if #(.DATA_BITS(8)) if_b ();
    uart_rx_param_if #(.DATA_BITS(7)) if_c ();

    uart_rx_param #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
                    .PARITY(0), .STOP_BITS(1))
        u_a (.clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_if(if_a));
    uart_rx_param #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(8),
                    .PARITY(2), .STOP_BITS(1))
        u_b (.clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_if(if_b));
    uart_rx_param #(.CLK_HZ(1_000_000), .BITRATE_BPS(100_000), .DATA_BITS(7),
                    .PARITY(0), .STOP_BITS(2))
        u_c (.clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_if(if_c));

    // Output monitor: latest presented word per instance plus cycle counters.
    logic [8:0] cap_data [3] = '{9'h0, 9'h0, 9'h0};
    logic       cap_perr [3] = '{1'b0, 1'b0, 1'b0};
    logic       cap_ferr [3] = '{1'b0, 1'b0, 1'b0};
    logic       cap_brk  [3] = '{1'b0, 1'b0, 1'b0};
    int         vcnt     [3] = '{0, 0, 0};
    int         ocnt     [3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (if_a.data_valid) begin
            cap_data[0] <= 9'(if_a.data);
            cap_perr[0] <= if_a.parity_err;
            cap_ferr[0] <= if_a.frame_err;
            cap_brk[0]  <= if_a.break_det;
            vcnt[0]     <= vcnt[0] + 1;
        end
        if (if_b.data_valid) begin
            cap_data[1] <= 9'(if_b.data);
            cap_perr[1] <= if_b.parity_err;
            cap_ferr[1] <= if_b.frame_err;
            cap_brk[1]  <= if_b.break_det;
            vcnt[1]     <= vcnt[1] + 1;
        end
        if (if_c.data_valid) begin
            cap_data[2] <= 9'(if_c.data);
            cap_perr[2] <= if_c.parity_err;
            cap_ferr[2] <= if_c.frame_err;
            cap_brk[2]  <= if_c.break_det;
            vcnt[2]     <= vcnt[2] + 1;
        end
        if (if_a.overrun) ocnt[0] <= ocnt[0] + 1;
        if (if_b.overrun) ocnt[1] <= ocnt[1] + 1;
        if (if_c.overrun) ocnt[2] <= ocnt[2] + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_rx(input int d, input logic v);
        case (d)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_bits(input int d, input logic [15:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(d, frame[i]);
            repeat (10) @(negedge clk);
        end
        set_rx(d, 1'b1);
    endtask

    function automatic void build(input logic [8:0] data, input int dbits, input logic has_par,
                                  input logic par, input int nstop, input logic [1:0] stops,
                                  output logic [15:0] f, output int n);
        f = '1;
        n = 0;
        f[n] = 1'b0; n++;
        for (int i = 0; i < dbits; i++) begin f[n] = data[i]; n++; end
        if (has_par) begin f[n] = par; n++; end
        for (int s = 0; s < nstop; s++) begin f[n] = stops[s]; n++; end
    endfunction

    typedef struct {
        int         d;
        logic [8:0] data;
        int         dbits;
        logic       has_par;
        logic       par;
        int         nstop;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [15:0] f;
        int n, v0, o0;

        vecs[0]  = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{0, 9'h000, 8, 1'b0, 1'b0, 1, 2'b11, 9'h000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b10, 9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{0, 9'h000, 8, 1'b0, 1'b0, 1, 2'b10, 9'h000, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1, 9'h03C, 8, 1'b1, 1'b0, 1, 2'b11, 9'h03C, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1, 9'h03C, 8, 1'b1, 1'b1, 1, 2'b11, 9'h03C, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1, 9'h001, 8, 1'b1, 1'b1, 1, 2'b11, 9'h001, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1, 9'h000, 8, 1'b1, 1'b1, 1, 2'b10, 9'h000, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{2, 9'h055, 7, 1'b0, 1'b0, 2, 2'b01, 9'h055, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{2, 9'h02A, 7, 1'b0, 1'b0, 2, 2'b11, 9'h02A, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{2, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b10, 9'h07F, 1'b0, 1'b1, 1'b0};

        if_a.data_ready = 1'b1;
        if_b.data_ready = 1'b1;
        if_c.data_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_data", 32'(if_a.data), 0);
        check("rst_a_valid", 32'(if_a.data_valid), 0);
        check("rst_a_flags", 32'({if_a.parity_err, if_a.frame_err, if_a.break_det, if_a.overrun}), 0);
        check("rst_b_valid", 32'(if_b.data_valid), 0);
        check("rst_c_valid", 32'(if_c.data_valid), 0);
        check("rst_a_state", 32'(u_a.state), 32'(IDLE));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int k = 0; k < 11; k++) begin
            build(vecs[k].data, vecs[k].dbits, vecs[k].has_par, vecs[k].par,
                  vecs[k].nstop, vecs[k].stops, f, n);
            v0 = vcnt[vecs[k].d];
            o0 = ocnt[vecs[k].d];
            send_bits(vecs[k].d, f, n);
            repeat (20) @(negedge clk);
            check($sformatf("v%0d_data", k), 32'(cap_data[vecs[k].d]), 32'(vecs[k].exp_data));
            check($sformatf("v%0d_perr", k), 32'(cap_perr[vecs[k].d]), 32'(vecs[k].exp_perr));
            check($sformatf("v%0d_ferr", k), 32'(cap_ferr[vecs[k].d]), 32'(vecs[k].exp_ferr));
            check($sformatf("v%0d_brk", k), 32'(cap_brk[vecs[k].d]), 32'(vecs[k].exp_brk));
            check($sformatf("v%0d_valid_cycles", k), 32'(vcnt[vecs[k].d] - v0), 1);
            check($sformatf("v%0d_overrun", k), 32'(ocnt[vecs[k].d] - o0), 0);
        end

        // Glitch shorter than half a bit is rejected
        v0 = vcnt[0];
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_valid", 32'(vcnt[0] - v0), 0);
        check("glitch_idle", 32'(u_a.state), 32'(IDLE));

        // Line held low for 20 bit times on 7N2: exactly one break word
        v0 = vcnt[2];
        rx_c = 1'b0;
        repeat (200) @(negedge clk);
        check("break_words", 32'(vcnt[2] - v0), 1);
        check("break_data", 32'(cap_data[2]), 0);
        check("break_ferr", 32'(cap_ferr[2]), 1);
        check("break_det", 32'(cap_brk[2]), 1);
        rx_c = 1'b1;
        repeat (30) @(negedge clk);
        check("break_no_retrigger", 32'(vcnt[2] - v0), 1);

        // Overrun: second frame dropped while first still presented
        if_a.data_ready = 1'b0;
        o0 = ocnt[0];
        build(9'h011, 8, 1'b0, 1'b0, 1, 2'b11, f, n);
        send_bits(0, f, n);
        build(9'h022, 8, 1'b0, 1'b0, 1, 2'b11, f, n);
        send_bits(0, f, n);
        repeat (20) @(negedge clk);
        check("ovr_data_kept", 32'(if_a.data), 32'h11);
        check("ovr_valid_held", 32'(if_a.data_valid), 1);
        check("ovr_pulses", 32'(ocnt[0] - o0), 1);
        if_a.data_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_valid_drop", 32'(if_a.data_valid), 0);
        @(negedge clk);

        // Reset during data bit 4 of 0xFF while a word is presented
        if_a.data_ready = 1'b0;
        build(9'h05A, 8, 1'b0, 1'b0, 1, 2'b11, f, n);
        send_bits(0, f, n);
        repeat (20) @(negedge clk);
        check("pre_rst_valid", 32'(if_a.data_valid), 1);
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(if_a.data), 0);
        check("midrst_valid", 32'(if_a.data_valid), 0);
        check("midrst_state", 32'(u_a.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        if_a.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcnt[0];
        build(9'h081, 8, 1'b0, 1'b0, 1, 2'b11, f, n);
        send_bits(0, f, n);
        repeat (20) @(negedge clk);
        check("postrst_data", 32'(cap_data[0]), 32'h81);
        check("postrst_flags", 32'({cap_perr[0], cap_ferr[0], cap_brk[0]}), 0);
        check("postrst_words", 32'(vcnt[0] - v0), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8-bit receiver in the serial front end. Configurable data width, parity mode and stop-bit count. Adds mid-bit sampling with false-start rejection, parity/framing/break detection, and a valid/ready output handshake with overrun reporting. Sits between the pad-level rx line and the byte-stream consumer (command parser / FIFO).

Parameters:
CLK_HZ, 66_000_000, system clock frequency in Hz
BITRATE_BPS, 9_600, line bit rate
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2
BIT_CLKS, CLK_HZ/BITRATE_BPS rounded to nearest integer (derived), clocks per bit, must be >= 8

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rx  in  1  asynchronous serial input, idle high
data  out  DATA_BITS  received word, LSB = first bit on the line
data_valid  out  1  data and error flags are valid; held until accepted
data_ready  in  1  consumer accepts the word when data_valid && data_ready
parity_err  out  1  parity mismatch for the presented word; always 0 when PARITY = 0
frame_err  out  1  at least one stop bit sampled low for the presented word
break_det  out  1  presented frame is all-zero data, parity (if any) and stop
overrun  out  1  one-cycle pulse: a frame completed while data_valid was still high

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. In reset, all outputs are 0, data is 0, the FSM is in IDLE, and the synchroniser flops are 1.
- Input synchroniser: rx passes through a 2-flop synchroniser to give rx_s. All logic uses rx_s only.
- Counters: bit-time counter of width $clog2(BIT_CLKS); bit index of width $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on a falling edge of rx_s (prev 1, now 0), clear the counter and go to START.
- START: at count BIT_CLKS/2 (integer division), sample rx_s.
  - Sample = 1: false start; return to IDLE.
  - Sample = 0: clear the counter; the sample point is now mid-bit. Go to DATA.
- DATA: each bit is sampled when the counter reaches BIT_CLKS-1; the counter then wraps to 0.
  - Shift the sample into the shift register LSB-first.
  - After DATA_BITS samples, go to PAR if PARITY != 0, else go to STOP.
- PAR: sample one bit at the same cadence. Compute the expected bit as XOR(data), inverted for odd parity. A mismatch sets the internal parity flag.
- STOP: sample STOP_BITS bits at the same cadence. Any low sample sets the internal frame flag. Completion happens on the cycle of the last stop sample.
- Frame completion:
  - If data_valid = 0 or (data_valid && data_ready) in that cycle: load data and all flags into the output registers. data_valid = 1 from the next cycle.
  - Otherwise: keep the output registers, drop the new frame, and pulse overrun = 1 for one cycle.
  - break_det = frame_err && shift register == 0 && (PARITY == 0 || parity sample == 0).
  - FSM returns to IDLE on completion.
- Line held low (break): after a break, IDLE requires rx_s to return high before a new falling edge is recognised. No re-trigger occurs while the line stays low.
- Handshake:
  - data_valid && data_ready clears data_valid on the next edge, unless a new completion coincides; in that case the new word loads and data_valid stays 1.
  - data, parity_err, frame_err and break_det are stable while data_valid = 1.
- Latency: data_valid rises 2 (synchroniser) + about (1.5 + DATA_BITS + P + STOP_BITS − 1) × BIT_CLKS + 1 clocks after the rx falling edge, where P = 1 if parity is enabled, else 0.
- Reset mid-frame: the frame is discarded and outputs clear. The next falling edge after rst_n release starts a new frame.
- data_ready is ignored when data_valid = 0.

Decomposition:
- Package uart_pkg:
  - parity_e enum {PAR_NONE, PAR_ODD, PAR_EVEN}
  - rx_state_e enum {IDLE, START, DATA, PAR, STOP}
  - function calc_bit_clks(clk_hz, bps) returning rounded clocks per bit
  - parity helper function
- Sub-module uart_bit_timer: counter with half-bit and full-bit strobe outputs, plus clear and enable inputs. Reusable by the future transmitter.
- The synchroniser stays inline.

Test Plan:
- All tests use CLK_HZ = 1_000_000 and BITRATE_BPS = 100_000, so BIT_CLKS = 10.
- 8N1 (defaults): send 0xA5 with data_ready = 1 → data = 0xA5, data_valid high for 1 cycle, all error flags 0.
- 8E1 (PARITY = 2): send 0x3C with parity bit 0 → no error; resend with parity bit 1 → data = 0x3C, parity_err = 1.
- 7N2 (DATA_BITS = 7, STOP_BITS = 2): send 0x55 with the second stop bit low → frame_err = 1, break_det = 0. Hold rx low for 20 bit times → one word, data = 0, frame_err = 1, break_det = 1, and no further data_valid until rx returns high.
- Glitch: drive rx low for 3 clocks, then high → no data_valid, FSM back in IDLE.
- Overrun: data_ready = 0, send 0x11 then 0x22 back-to-back → data stays 0x11, overrun pulses once at the end of the 0x22 frame. Then raise data_ready → data_valid drops next cycle.
- Reset mid-frame: assert rst_n = 0 during data bit 4 of 0xFF → all outputs 0 immediately. After release, send 0x81 → data = 0x81 with no errors.
